octant_rom_arbiter: RTL

OCTANT_ROM_ARBITER -- requirements
Module: octant_rom_arbiter

---
 rtl/octant_rom_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/octant_rom_arbiter.sv
// Round-robin arbiter sharing one fixed-latency octant ROM between NUM_REQ requesters.
// Grants one read per cycle; a ROM_LAT-deep tag pipeline routes each ROM word back to its requester.
module octant_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_ren,
    input  logic [DATA_W-1:0]         rom_dout,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ROM_LAT-1:0] tag_vld_q;
    logic [IDX_W-1:0]  tag_idx_q [ROM_LAT];

    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    int unsigned       idx;

    // First valid requester at or above rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
        if (reset) begin
            win_vld = 1'b0;
        end
    end

    always_comb begin
        rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        rom_ren   = win_vld;
        rom_addr  = addr_q;
        if (win_vld) begin
            req_ready[win_idx] = 1'b1;
            rom_addr           = req_addr[win_idx*ADDR_W +: ADDR_W];
        end
    end

    // ROM data is passed straight through in the cycle the tag emerges.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_vld_q[ROM_LAT-1] && !reset) begin
            rsp_valid[tag_idx_q[ROM_LAT-1]] = 1'b1;
            rsp_data                        = rom_dout;
        end
    end

    assign busy = |tag_vld_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            addr_q    <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= win_vld;
            tag_idx_q[0] <= win_idx;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
            if (win_vld) begin
                rr_ptr_q <= rr_ptr_d;
                addr_q   <= rom_addr;
            end
        end
    end

endmodule
